// File: rtl/cpu_sequencer.sv
// Instruction-cycle controller: owns the PC, sequences fetch/decode/execute,
// resolves jumps and halts locally and guards execute with a watchdog.
module cpu_sequencer #(
    parameter int          TIMEOUT = 255,
    parameter logic [3:0]  JMP_OP  = 4'hD,
    parameter logic [3:0]  JZ_OP   = 4'hE,
    parameter logic [3:0]  HLT_OP  = 4'hF
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        RUN,
    input  logic [15:0] PC_START,
    input  logic        MEM_READY,
    input  logic [3:0]  OPCODE,
    input  logic [7:0]  ADDRESS,
    input  logic        EXEC_DONE,
    input  logic        ZERO,
    output logic [15:0] PC,
    output logic        FETCH_REQ,
    output logic        EXEC_START,
    output logic        BUSY,
    output logic        HALTED,
    output logic        ERROR,
    output logic [15:0] INSTR_CNT,
    output logic [2:0]  STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT);

    state_t      state, state_n;
    logic [15:0] pc, pc_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] wd, wd_n;
    logic        z, z_n;
    logic        err, err_n;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= S_IDLE;
            pc    <= '0;
            cnt   <= '0;
            wd    <= '0;
            z     <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            cnt   <= cnt_n;
            wd    <= wd_n;
            z     <= z_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        cnt_n   = cnt;
        wd_n    = wd;
        z_n     = z;
        err_n   = err;
        case (state)
            S_IDLE: begin
                if (RUN) begin
                    pc_n    = PC_START;
                    cnt_n   = '0;
                    state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (MEM_READY)
                    state_n = S_DECODE;
            end
            S_DECODE: begin
                // halt outranks jumps if opcode parameters ever overlap
                if (OPCODE == HLT_OP) begin
                    cnt_n   = cnt + 16'd1;
                    state_n = S_HALT;
                end else if (OPCODE == JMP_OP) begin
                    pc_n    = {8'h00, ADDRESS};
                    cnt_n   = cnt + 16'd1;
                    state_n = S_FETCH;
                end else if (OPCODE == JZ_OP) begin
                    pc_n    = z ? {8'h00, ADDRESS} : pc + 16'd1;
                    cnt_n   = cnt + 16'd1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                wd_n    = '0;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (EXEC_DONE) begin
                    z_n     = ZERO;
                    pc_n    = pc + 16'd1;
                    cnt_n   = cnt + 16'd1;
                    state_n = S_FETCH;
                end else begin
                    wd_n = wd + 16'd1;
                    if (wd_n == WD_LIMIT) begin
                        err_n   = 1'b1;
                        state_n = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (!RUN) begin
                    err_n   = 1'b0;
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign PC         = pc;
    assign INSTR_CNT  = cnt;
    assign ERROR      = err;
    assign STATE      = state;
    assign FETCH_REQ  = (state == S_FETCH);
    assign EXEC_START = (state == S_EXEC);
    assign HALTED     = (state == S_HALT);
    assign BUSY       = (state != S_IDLE) && (state != S_HALT);

endmodule
